// File: rtl/bp_tlb_fill_ctrl.sv
// Refill sequencer for an ITLB/DTLB pair sharing one page-table walker.
// Captures misses, arbitrates round-robin, walks one vtag at a time and writes the leaf back.
module bp_tlb_fill_ctrl #(
    parameter int vtag_width_p  = 27,
    parameter int entry_width_p = 36
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,

    input  logic                     itlb_miss_v_i,
    input  logic [vtag_width_p-1:0]  itlb_miss_vtag_i,
    input  logic                     dtlb_miss_v_i,
    input  logic [vtag_width_p-1:0]  dtlb_miss_vtag_i,
    output logic                     itlb_busy_o,
    output logic                     dtlb_busy_o,

    output logic                     ptw_v_o,
    output logic [vtag_width_p-1:0]  ptw_vtag_o,
    input  logic                     ptw_ready_i,
    input  logic                     ptw_v_i,
    input  logic                     ptw_fault_i,
    input  logic [entry_width_p-1:0] ptw_entry_i,

    output logic                     itlb_w_v_o,
    output logic                     dtlb_w_v_o,
    output logic [vtag_width_p-1:0]  tlb_w_vtag_o,
    output logic [entry_width_p-1:0] tlb_w_entry_o,

    output logic                     fault_v_o,
    output logic                     fault_itlb_o,
    output logic [vtag_width_p-1:0]  fault_vtag_o
);

    typedef enum logic [2:0] {
        e_idle,
        e_req,
        e_wait,
        e_fill,
        e_drain
    } state_e;

    state_e state_r, state_n;

    logic                     itlb_pend_r, dtlb_pend_r;
    logic                     itlb_pend_n, dtlb_pend_n;
    logic [vtag_width_p-1:0]  itlb_vtag_r, dtlb_vtag_r;

    logic                     last_itlb_r;
    logic                     grant_itlb_r;
    logic [vtag_width_p-1:0]  grant_vtag_r;
    logic [entry_width_p-1:0] entry_r;

    logic                     fault_v_r;
    logic                     fault_itlb_r;
    logic [vtag_width_p-1:0]  fault_vtag_r;

    logic itlb_capture, dtlb_capture;
    logic pick_itlb, grant_v;
    logic resp_fill, done_fill, done_fault;
    logic fill_v;

    // A side with a refill pending or in flight ignores further misses until it completes.
    assign itlb_capture = itlb_miss_v_i & ~itlb_pend_r & ~flush_i;
    assign dtlb_capture = dtlb_miss_v_i & ~dtlb_pend_r & ~flush_i;

    assign pick_itlb  = itlb_pend_r & (~dtlb_pend_r | ~last_itlb_r);
    assign grant_v    = (state_r == e_idle) & ~flush_i & (itlb_pend_r | dtlb_pend_r);

    assign resp_fill  = (state_r == e_wait) & ptw_v_i & ~ptw_fault_i & ~flush_i;
    assign done_fault = (state_r == e_wait) & ptw_v_i &  ptw_fault_i & ~flush_i;
    assign done_fill  = (state_r == e_fill) & ~flush_i;

    always_comb begin
        state_n = state_r;
        case (state_r)
            e_idle: begin
                if (grant_v) state_n = e_req;
            end
            e_req: begin
                if (flush_i)          state_n = e_idle;
                else if (ptw_ready_i) state_n = e_wait;
            end
            e_wait: begin
                if (flush_i)      state_n = ptw_v_i ? e_idle : e_drain;
                else if (ptw_v_i) state_n = ptw_fault_i ? e_idle : e_fill;
            end
            e_fill: begin
                state_n = e_idle;
            end
            // The abandoned walk's response ends the drain even under a new flush.
            e_drain: begin
                if (ptw_v_i) state_n = e_idle;
            end
            default: state_n = e_idle;
        endcase
    end

    always_comb begin
        itlb_pend_n = itlb_pend_r;
        dtlb_pend_n = dtlb_pend_r;
        if ((done_fill | done_fault) &  grant_itlb_r) itlb_pend_n = 1'b0;
        if ((done_fill | done_fault) & ~grant_itlb_r) dtlb_pend_n = 1'b0;
        if (itlb_capture) itlb_pend_n = 1'b1;
        if (dtlb_capture) dtlb_pend_n = 1'b1;
        if (flush_i) begin
            itlb_pend_n = 1'b0;
            dtlb_pend_n = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r      <= e_idle;
            itlb_pend_r  <= 1'b0;
            dtlb_pend_r  <= 1'b0;
            itlb_vtag_r  <= '0;
            dtlb_vtag_r  <= '0;
            last_itlb_r  <= 1'b1;
            grant_itlb_r <= 1'b0;
            grant_vtag_r <= '0;
            entry_r      <= '0;
            fault_v_r    <= 1'b0;
            fault_itlb_r <= 1'b0;
            fault_vtag_r <= '0;
        end else begin
            state_r     <= state_n;
            itlb_pend_r <= itlb_pend_n;
            dtlb_pend_r <= dtlb_pend_n;
            if (itlb_capture) itlb_vtag_r <= itlb_miss_vtag_i;
            if (dtlb_capture) dtlb_vtag_r <= dtlb_miss_vtag_i;
            if (grant_v) begin
                grant_itlb_r <= pick_itlb;
                grant_vtag_r <= pick_itlb ? itlb_vtag_r : dtlb_vtag_r;
            end
            if (resp_fill) entry_r <= ptw_entry_i;
            fault_v_r <= done_fault;
            if (done_fault) begin
                fault_itlb_r <= grant_itlb_r;
                fault_vtag_r <= grant_vtag_r;
            end
            if (done_fill | done_fault) last_itlb_r <= grant_itlb_r;
        end
    end

    // Data outputs are zeroed whenever their strobe is low, so idle outputs read all-zero.
    assign itlb_busy_o   = itlb_pend_r;
    assign dtlb_busy_o   = dtlb_pend_r;

    assign ptw_v_o       = (state_r == e_req) & ~flush_i;
    assign ptw_vtag_o    = ptw_v_o ? grant_vtag_r : '0;

    assign fill_v        = done_fill;
    assign itlb_w_v_o    = fill_v &  grant_itlb_r;
    assign dtlb_w_v_o    = fill_v & ~grant_itlb_r;
    assign tlb_w_vtag_o  = fill_v ? grant_vtag_r : '0;
    assign tlb_w_entry_o = fill_v ? entry_r : '0;

    assign fault_v_o     = fault_v_r & ~flush_i;
    assign fault_itlb_o  = fault_v_o & fault_itlb_r;
    assign fault_vtag_o  = fault_v_o ? fault_vtag_r : '0;

    // Requesters must stall while busy, and the walker only answers outstanding walks.
    a_itlb_miss_not_busy: assert property (@(posedge clk_i) disable iff (reset_i)
        (itlb_miss_v_i && !flush_i) |-> !itlb_pend_r);
    a_dtlb_miss_not_busy: assert property (@(posedge clk_i) disable iff (reset_i)
        (dtlb_miss_v_i && !flush_i) |-> !dtlb_pend_r);
    a_ptw_resp_expected: assert property (@(posedge clk_i) disable iff (reset_i)
        ptw_v_i |-> (state_r == e_wait || state_r == e_drain));

endmodule

// File: tb/tb_bp_tlb_fill_ctrl.sv
// Scoreboard bench for bp_tlb_fill_ctrl: directed misses, a latency-programmable walker model,
// and a monitor that matches every handshake, fill and fault against the expected queue.
module tb_bp_tlb_fill_ctrl;

    localparam int VW = 27;
    localparam int EW = 36;
    localparam int K_REQ   = 0;
    localparam int K_FILL  = 1;
    localparam int K_FAULT = 2;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          flush_i;
    logic          itlb_miss_v_i;
    logic [VW-1:0] itlb_miss_vtag_i;
    logic          dtlb_miss_v_i;
    logic [VW-1:0] dtlb_miss_vtag_i;
    logic          itlb_busy_o;
    logic          dtlb_busy_o;
    logic          ptw_v_o;
    logic [VW-1:0] ptw_vtag_o;
    logic          ptw_ready_i;
    logic          ptw_v_i;
    logic          ptw_fault_i;
    logic [EW-1:0] ptw_entry_i;
    logic          itlb_w_v_o;
    logic          dtlb_w_v_o;
    logic [VW-1:0] tlb_w_vtag_o;
    logic [EW-1:0] tlb_w_entry_o;
    logic          fault_v_o;
    logic          fault_itlb_o;
    logic [VW-1:0] fault_vtag_o;

    typedef struct {
        int            kind;
        logic          itlb;
        logic [VW-1:0] vtag;
        logic [EW-1:0] entry;
        int            cyc;
    } ev_t;

    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;

    int            rsp_lat   = 0;
    logic          rsp_fault = 1'b0;
    logic [EW-1:0] rsp_entry = '0;

    bp_tlb_fill_ctrl #(.vtag_width_p(VW), .entry_width_p(EW)) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .flush_i          (flush_i),
        .itlb_miss_v_i    (itlb_miss_v_i),
        .itlb_miss_vtag_i (itlb_miss_vtag_i),
        .dtlb_miss_v_i    (dtlb_miss_v_i),
        .dtlb_miss_vtag_i (dtlb_miss_vtag_i),
        .itlb_busy_o      (itlb_busy_o),
        .dtlb_busy_o      (dtlb_busy_o),
        .ptw_v_o          (ptw_v_o),
        .ptw_vtag_o       (ptw_vtag_o),
        .ptw_ready_i      (ptw_ready_i),
        .ptw_v_i          (ptw_v_i),
        .ptw_fault_i      (ptw_fault_i),
        .ptw_entry_i      (ptw_entry_i),
        .itlb_w_v_o       (itlb_w_v_o),
        .dtlb_w_v_o       (dtlb_w_v_o),
        .tlb_w_vtag_o     (tlb_w_vtag_o),
        .tlb_w_entry_o    (tlb_w_entry_o),
        .fault_v_o        (fault_v_o),
        .fault_itlb_o     (fault_itlb_o),
        .fault_vtag_o     (fault_vtag_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] all_out();
        return {4'b0, itlb_busy_o, dtlb_busy_o, ptw_v_o, ptw_vtag_o, itlb_w_v_o, dtlb_w_v_o,
                tlb_w_vtag_o, tlb_w_entry_o, fault_v_o, fault_itlb_o, fault_vtag_o};
    endfunction

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input logic itlb, input logic [VW-1:0] vtag,
                           input logic [EW-1:0] entry, input int c);
        ev_t e;
        e.kind  = kind;
        e.itlb  = itlb;
        e.vtag  = vtag;
        e.entry = entry;
        e.cyc   = c;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic itlb, input logic [VW-1:0] vtag,
                           input logic [EW-1:0] entry);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL unexpected_event: got kind %0d vtag 0x%0h at cycle %0d, expected none",
                     kind, vtag, cyc);
        end else begin
            e = exp_q.pop_front();
            check_output("event_kind", kind, e.kind);
            check_output("event_vtag", vtag, e.vtag);
            if (kind != K_REQ)  check_output("event_side", itlb, e.itlb);
            if (kind == K_FILL) check_output("event_entry", entry, e.entry);
            if (e.cyc >= 0)     check_output("event_cycle", cyc, e.cyc);
        end
    endtask

    // Monitor: every handshake, fill strobe and fault pulse must match the next expected event.
    always @(negedge clk) begin
        if (!reset_i) begin
            if (ptw_v_o && ptw_ready_i) observe(K_REQ, 1'b0, ptw_vtag_o, '0);
            if (itlb_w_v_o)             observe(K_FILL, 1'b1, tlb_w_vtag_o, tlb_w_entry_o);
            if (dtlb_w_v_o)             observe(K_FILL, 1'b0, tlb_w_vtag_o, tlb_w_entry_o);
            if (fault_v_o)              observe(K_FAULT, fault_itlb_o, fault_vtag_o, '0);
        end
    end

    // Walker model: answers each accepted request rsp_lat cycles after the handshake.
    initial begin
        int lat;
        ptw_v_i     = 1'b0;
        ptw_fault_i = 1'b0;
        ptw_entry_i = '0;
        forever begin
            @(negedge clk);
            if (!reset_i && ptw_v_o && ptw_ready_i) begin
                lat = rsp_lat;
                @(posedge clk);
                repeat (lat) @(posedge clk);
                #1;
                ptw_v_i     = 1'b1;
                ptw_fault_i = rsp_fault;
                ptw_entry_i = rsp_entry;
                @(posedge clk);
                #1;
                ptw_v_i     = 1'b0;
                ptw_fault_i = 1'b0;
                ptw_entry_i = '0;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic iv, input logic [VW-1:0] itag,
                                  input logic dv, input logic [VW-1:0] dtag);
        itlb_miss_v_i    = iv;
        itlb_miss_vtag_i = itag;
        dtlb_miss_v_i    = dv;
        dtlb_miss_vtag_i = dtag;
        tick(1);
        itlb_miss_v_i    = 1'b0;
        itlb_miss_vtag_i = '0;
        dtlb_miss_v_i    = 1'b0;
        dtlb_miss_vtag_i = '0;
    endtask

    initial begin
        int t;
        reset_i          = 1'b1;
        flush_i          = 1'b0;
        itlb_miss_v_i    = 1'b0;
        itlb_miss_vtag_i = '0;
        dtlb_miss_v_i    = 1'b0;
        dtlb_miss_vtag_i = '0;
        ptw_ready_i      = 1'b1;
        tick(3);
        reset_i = 1'b0;
        @(negedge clk);
        check_output("reset_outputs", all_out(), '0);
        tick(1);

        // Single ITLB refill with a 3-cycle walk
        rsp_lat = 3; rsp_entry = 36'hABC; rsp_fault = 1'b0;
        t = cyc;
        push_ev(K_REQ, 1'b0, 27'h123, '0, t + 2);
        push_ev(K_FILL, 1'b1, 27'h123, 36'hABC, t + 7);
        apply_stimulus(1'b1, 27'h123, 1'b0, '0);
        @(negedge clk);
        check_output("t1_busy_after_miss", {itlb_busy_o, dtlb_busy_o}, 2'b10);
        tick(8);
        @(negedge clk);
        check_output("t1_busy_after_fill", {itlb_busy_o, dtlb_busy_o}, 2'b00);
        tick(1);

        // Simultaneous misses: DTLB first; ITLB walk is then flushed in REQ
        rsp_lat = 1; rsp_entry = 36'h2E1;
        t = cyc;
        push_ev(K_REQ, 1'b0, 27'h0D1, '0, t + 2);
        push_ev(K_FILL, 1'b0, 27'h0D1, 36'h2E1, t + 5);
        apply_stimulus(1'b1, 27'h0A1, 1'b1, 27'h0D1);
        tick(4);
        ptw_ready_i = 1'b0;
        tick(2);
        @(negedge clk);
        check_output("t2_itlb_req", {ptw_v_o, ptw_vtag_o}, {1'b1, 27'h0A1});
        tick(1);
        @(negedge clk);
        check_output("t2_itlb_req_hold", {ptw_v_o, ptw_vtag_o}, {1'b1, 27'h0A1});
        tick(1);
        flush_i = 1'b1;
        tick(1);
        flush_i = 1'b0;
        @(negedge clk);
        check_output("t2_after_flush", {itlb_busy_o, dtlb_busy_o, ptw_v_o}, 3'b000);
        ptw_ready_i = 1'b1;
        tick(1);

        // Next simultaneous pair: last grant was DTLB, so ITLB goes first
        t = cyc;
        push_ev(K_REQ, 1'b0, 27'h0A2, '0, t + 2);
        push_ev(K_FILL, 1'b1, 27'h0A2, 36'h2E1, t + 5);
        push_ev(K_REQ, 1'b0, 27'h0D2, '0, t + 7);
        push_ev(K_FILL, 1'b0, 27'h0D2, 36'h2E1, t + 10);
        apply_stimulus(1'b1, 27'h0A2, 1'b1, 27'h0D2);
        tick(12);

        // DTLB request held while the walker is not ready
        rsp_lat = 2; rsp_entry = 36'h355;
        ptw_ready_i = 1'b0;
        t = cyc;
        push_ev(K_REQ, 1'b0, 27'h055, '0, t + 7);
        push_ev(K_FILL, 1'b0, 27'h055, 36'h355, t + 11);
        apply_stimulus(1'b0, '0, 1'b1, 27'h055);
        tick(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("t3_req_stable", {ptw_v_o, ptw_vtag_o}, {1'b1, 27'h055});
            tick(1);
        end
        ptw_ready_i = 1'b1;
        tick(6);

        // DTLB page fault
        rsp_lat = 0; rsp_fault = 1'b1;
        t = cyc;
        push_ev(K_REQ, 1'b0, 27'h07F, '0, t + 2);
        push_ev(K_FAULT, 1'b0, 27'h07F, '0, t + 4);
        apply_stimulus(1'b0, '0, 1'b1, 27'h07F);
        tick(5);
        @(negedge clk);
        check_output("t4_busy_after_fault", dtlb_busy_o, 1'b0);
        rsp_fault = 1'b0;
        tick(2);

        // Flush during WAIT, response 4 cycles later, new DTLB miss during the drain
        rsp_lat = 5; rsp_entry = 36'h5D5;
        t = cyc;
        push_ev(K_REQ, 1'b0, 27'h0BE, '0, t + 2);
        push_ev(K_REQ, 1'b0, 27'h0D5, '0, t + 10);
        push_ev(K_FILL, 1'b0, 27'h0D5, 36'h5D5, t + 13);
        apply_stimulus(1'b1, 27'h0BE, 1'b0, '0);
        tick(3);
        flush_i = 1'b1;
        tick(1);
        flush_i = 1'b0;
        @(negedge clk);
        check_output("t5_busy_after_flush", {itlb_busy_o, ptw_v_o}, 2'b00);
        rsp_lat = 1;
        tick(1);
        apply_stimulus(1'b0, '0, 1'b1, 27'h0D5);
        tick(9);

        // Flush in the FILL cycle suppresses the write
        rsp_lat = 0; rsp_entry = 36'h6C6;
        t = cyc;
        push_ev(K_REQ, 1'b0, 27'h0C6, '0, t + 2);
        apply_stimulus(1'b1, 27'h0C6, 1'b0, '0);
        tick(3);
        flush_i = 1'b1;
        @(negedge clk);
        check_output("t6_fill_suppressed", {itlb_w_v_o, dtlb_w_v_o}, 2'b00);
        tick(1);
        flush_i = 1'b0;
        @(negedge clk);
        check_output("t6_outputs_after_flush", all_out(), '0);
        tick(2);

        // Reset while in REQ, then reset round-robin state favours DTLB again
        ptw_ready_i = 1'b0;
        apply_stimulus(1'b0, '0, 1'b1, 27'h0C7);
        tick(1);
        @(negedge clk);
        check_output("t6_req_before_reset", ptw_v_o, 1'b1);
        tick(1);
        reset_i = 1'b1;
        tick(1);
        reset_i = 1'b0;
        @(negedge clk);
        check_output("t6_outputs_after_reset", all_out(), '0);
        ptw_ready_i = 1'b1;
        tick(1);

        rsp_lat = 0; rsp_entry = 36'h7E7;
        t = cyc;
        push_ev(K_REQ, 1'b0, 27'h0D9, '0, t + 2);
        push_ev(K_FILL, 1'b0, 27'h0D9, 36'h7E7, t + 4);
        push_ev(K_REQ, 1'b0, 27'h0E1, '0, t + 6);
        push_ev(K_FILL, 1'b1, 27'h0E1, 36'h7E7, t + 8);
        apply_stimulus(1'b1, 27'h0E1, 1'b1, 27'h0D9);
        tick(10);

        check_output("expected_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
